// File: rtl/treeval_pkg.sv
// Shared encodings for the treeval message channel (host driver and controller).
package treeval_pkg;

  localparam int unsigned W_MSG            = 64;
  localparam int unsigned W_ADDR           = 6;
  localparam int unsigned MAX_NODES        = 64;
  localparam int unsigned W_ACTION         = 3;
  localparam int unsigned W_REWARD         = 10;
  localparam int unsigned W_WEIGHT         = 8;
  localparam int unsigned MAX_DATA_WIDTH   = 16;
  localparam int unsigned MAX_CONFIG_WIDTH = 16;
  localparam int unsigned TIMEOUT_CYCLES   = 4096;

  localparam int unsigned CmdLsb    = 62;
  localparam int unsigned CfgLsb    = 60;
  localparam int unsigned AddrLsb   = 56;
  localparam int unsigned FieldLsb  = 54;
  localparam int unsigned ResExpLsb = 0;
  localparam int unsigned ResActLsb = 10;

  typedef enum logic [1:0] {CmdRun = 2'd0, CmdNode = 2'd1, CmdConfig = 2'd2} cmd_e;
  typedef enum logic [1:0] {CfgNodes = 2'd0} cfg_e;
  typedef enum logic [1:0] {
    FldParent = 2'd0, FldAction = 2'd1, FldReward = 2'd2, FldWeight = 2'd3
  } field_e;

  typedef enum logic [2:0] {
    StIdle, StSendCfg, StFetch, StCapture, StSendNode, StSendRun, StWaitResult, StDone
  } state_e;

  function automatic logic [W_MSG-1:0] mk_cfg(input logic [W_ADDR:0] n);
    logic [W_MSG-1:0] m;
    m = '0;
    m[CmdLsb+:2] = CmdConfig;
    m[CfgLsb+:2] = CfgNodes;
    m[MAX_CONFIG_WIDTH-1:0] = MAX_CONFIG_WIDTH'(n);
    return m;
  endfunction

  function automatic logic [W_MSG-1:0] mk_node(input logic [W_ADDR-1:0] addr, input field_e f,
                                               input logic [MAX_DATA_WIDTH-1:0] data);
    logic [W_MSG-1:0] m;
    m = '0;
    m[CmdLsb+:2] = CmdNode;
    m[AddrLsb+:W_ADDR] = addr;
    m[FieldLsb+:2] = f;
    m[MAX_DATA_WIDTH-1:0] = data;
    return m;
  endfunction

endpackage

// File: rtl/treeval_msg_tx.sv
// Holds one outgoing message under the rdy/ack handshake; accepted_o pulses on the ack edge.
module treeval_msg_tx
  import treeval_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [W_MSG-1:0] load_msg_i,
  output logic             out_msg_rdy_o,
  output logic [W_MSG-1:0] out_msg_o,
  input  logic             out_msg_ack_i,
  output logic             accepted_o
);

  logic             rdy_q;
  logic [W_MSG-1:0] msg_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_q <= 1'b0;
      msg_q <= '0;
    end else if (load_i) begin
      rdy_q <= 1'b1;
      msg_q <= load_msg_i;
    end else if (rdy_q && out_msg_ack_i) begin
      rdy_q <= 1'b0;
    end
  end

  assign accepted_o    = rdy_q & out_msg_ack_i;
  assign out_msg_rdy_o = rdy_q;
  assign out_msg_o     = msg_q;

endmodule

// File: rtl/treeval_host_driver.sv
// Host-side treeval initiator: streams a node table as commands, then waits for the result.
// Optional result watchdog enabled by defining TREEVAL_DRV_TIMEOUT_EN.
module treeval_host_driver
  import treeval_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W_ADDR:0]     num_nodes,
  output logic                node_rd_en,
  output logic [W_ADDR-1:0]   node_rd_addr,
  input  logic [W_ADDR-1:0]   node_parent,
  input  logic [W_ACTION-1:0] node_action,
  input  logic [W_REWARD-1:0] node_reward,
  input  logic [W_WEIGHT-1:0] node_weight,
  output logic                out_msg_rdy,
  output logic [W_MSG-1:0]    out_msg,
  input  logic                out_msg_ack,
  input  logic                in_msg_rdy,
  input  logic [W_MSG-1:0]    in_msg,
  output logic                in_msg_ack,
  output logic                busy,
  output logic                done,
  output logic [W_REWARD-1:0] result_exp,
  output logic [W_ACTION-1:0] result_act,
  output logic                timeout
);

  state_e              state_q;
  logic [W_ADDR:0]     n_q;
  logic [W_ADDR-1:0]   addr_q, rd_addr_q;
  field_e              field_q;
  logic [W_ADDR-1:0]   par_q;
  logic [W_ACTION-1:0] act_q;
  logic [W_REWARD-1:0] rew_q, res_exp_q;
  logic [W_WEIGHT-1:0] wt_q;
  logic [W_ACTION-1:0] res_act_q;
  logic                rd_en_q, load_q, busy_q, done_q, in_ack_q, timeout_q;
  logic [W_MSG-1:0]    ld_msg_q;
  logic                accepted, rx_take;
  field_e              next_field;
  logic [MAX_DATA_WIDTH-1:0] next_data;
  logic [W_ADDR:0]     n_clamped;
  logic                unused_in;

`ifdef TREEVAL_DRV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q;
`endif

  treeval_msg_tx u_tx (
    .clk_i         (clk),
    .rst_i         (rst),
    .load_i        (load_q),
    .load_msg_i    (ld_msg_q),
    .out_msg_rdy_o (out_msg_rdy),
    .out_msg_o     (out_msg),
    .out_msg_ack_i (out_msg_ack),
    .accepted_o    (accepted)
  );

  assign rx_take   = in_msg_rdy && !in_ack_q;
  assign n_clamped = (num_nodes > (W_ADDR+1)'(MAX_NODES)) ? (W_ADDR+1)'(MAX_NODES) : num_nodes;
  assign unused_in = ^{in_msg[W_MSG-1:ResActLsb+W_ACTION]};

  always_comb begin
    next_field = field_e'(field_q + 2'd1);
    next_data  = '0;
    case (next_field)
      FldParent: next_data = MAX_DATA_WIDTH'(par_q);
      FldAction: next_data = MAX_DATA_WIDTH'(act_q);
      FldReward: next_data = {{(MAX_DATA_WIDTH-W_REWARD){rew_q[W_REWARD-1]}}, rew_q};
      FldWeight: next_data = MAX_DATA_WIDTH'(wt_q);
      default:   next_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      n_q       <= '0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      field_q   <= FldParent;
      par_q     <= '0;
      act_q     <= '0;
      rew_q     <= '0;
      wt_q      <= '0;
      res_exp_q <= '0;
      res_act_q <= '0;
      rd_en_q   <= 1'b0;
      load_q    <= 1'b0;
      ld_msg_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      in_ack_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef TREEVAL_DRV_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      // Results are acked in every state; only WAIT_RESULT keeps them.
      in_ack_q <= rx_take;
      case (state_q)
        StIdle: begin
          if (start) begin
            n_q       <= n_clamped;
            addr_q    <= '0;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            load_q    <= 1'b1;
            ld_msg_q  <= mk_cfg(n_clamped);
            state_q   <= StSendCfg;
          end
        end
        StSendCfg: begin
          if (accepted) begin
            if (n_q != '0) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_q;
              state_q   <= StFetch;
            end else begin
              load_q   <= 1'b1;
              ld_msg_q <= '0;
              state_q  <= StSendRun;
            end
          end
        end
        StFetch: begin
          rd_en_q <= 1'b0;
          state_q <= StCapture;
        end
        StCapture: begin
          par_q    <= node_parent;
          act_q    <= node_action;
          rew_q    <= node_reward;
          wt_q     <= node_weight;
          field_q  <= FldParent;
          load_q   <= 1'b1;
          ld_msg_q <= mk_node(addr_q, FldParent, MAX_DATA_WIDTH'(node_parent));
          state_q  <= StSendNode;
        end
        StSendNode: begin
          if (accepted) begin
            if (field_q != FldWeight) begin
              field_q  <= next_field;
              load_q   <= 1'b1;
              ld_msg_q <= mk_node(addr_q, next_field, next_data);
            end else if ({1'b0, addr_q} == n_q - (W_ADDR+1)'(1)) begin
              load_q   <= 1'b1;
              ld_msg_q <= '0;
              state_q  <= StSendRun;
            end else begin
              addr_q    <= addr_q + 1'b1;
              rd_addr_q <= addr_q + 1'b1;
              rd_en_q   <= 1'b1;
              state_q   <= StFetch;
            end
          end
        end
        StSendRun: begin
          if (accepted) begin
            state_q <= StWaitResult;
`ifdef TREEVAL_DRV_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StWaitResult: begin
          if (rx_take) begin
            res_exp_q <= in_msg[ResExpLsb+:W_REWARD];
            res_act_q <= in_msg[ResActLsb+:W_ACTION];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StDone;
          end
`ifdef TREEVAL_DRV_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign node_rd_en   = rd_en_q;
  assign node_rd_addr = rd_addr_q;
  assign in_msg_ack   = in_ack_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result_exp   = res_exp_q;
  assign result_act   = res_act_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/treeval_host_driver.md
Name: treeval_host_driver

Overview:
- Host-side initiator for the treeval command protocol. It is the sending end of the 64-bit message channel that treeval_controller consumes.
- On `start`, it reads a node table through a synchronous read port and serialises it into messages, in this order: config (node count), then per-node PARENT/ACTION/REWARD/WEIGHT, then RUN.
- It then waits for the result message and presents the expected value and chosen action to the host.

Parameters:
- W_MSG, 64, message width
- W_ADDR, 6, node address width
- MAX_NODES, 64, table depth
- W_ACTION, 3, action width
- W_REWARD, 10, signed reward/expectation width
- W_WEIGHT, 8, weight width
- MAX_DATA_WIDTH, 16, node-data field width in a message
- MAX_CONFIG_WIDTH, 16, config-data field width
- TIMEOUT_CYCLES, 4096, result watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- num_nodes  in  W_ADDR+1  nodes to send
- node_rd_en  out  1  node table read strobe
- node_rd_addr  out  W_ADDR  node table address
- node_parent  in  W_ADDR  read data; valid 1 cycle after node_rd_en
- node_action  in  W_ACTION  read data
- node_reward  in  W_REWARD  signed read data
- node_weight  in  W_WEIGHT  read data
- out_msg_rdy  out  1  command message valid
- out_msg  out  W_MSG  command message
- out_msg_ack  in  1  controller accepted message
- in_msg_rdy  in  1  result message valid
- in_msg  in  W_MSG  result message
- in_msg_ack  out  1  result accepted
- busy  out  1  high from start accept until DONE
- done  out  1  one-cycle pulse when the result is latched
- result_exp  out  W_REWARD  signed expectation, held until next start
- result_act  out  W_ACTION  action, held until next start
- timeout  out  1  sticky error flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs are 0, including out_msg, result_*, and node_rd_addr. out_msg_rdy drops immediately; any in-flight message is abandoned.
- Message encoding:
  - cmd field is [63:62]: RUN=0, NODE=1, CONFIG=2.
  - CONFIG: [61:60]=0 (NODES); [15:0]=node count, zero-extended.
  - NODE: [61:56]=addr; [55:54]=field (PARENT=0, ACTION=1, REWARD=2, WEIGHT=3); [15:0]=data. Parent, action and weight are zero-extended; reward is sign-extended.
  - RUN: all zero.
  - Unused bits are 0.
- Send handshake:
  - Assert out_msg_rdy with out_msg stable.
  - On the cycle out_msg_ack=1 is sampled, deassert out_msg_rdy at the next edge and advance.
  - out_msg must not change while rdy=1.
  - Minimum one idle cycle between messages.
  - An ack while rdy=0 is ignored.
- Receive handshake:
  - In WAIT_RESULT, if in_msg_rdy && !in_msg_ack: latch result_exp=in_msg[9:0] and result_act=in_msg[12:10], pulse in_msg_ack for one cycle, and go to DONE.
  - In any other state, in_msg_rdy is acked and discarded.
- FSM transitions:
  - IDLE: start → capture N=min(num_nodes, MAX_NODES), busy=1, go to SEND_CFG.
  - SEND_CFG: ack → FETCH if N>0, else SEND_RUN.
  - FETCH: node_rd_en=1 for one cycle, then capture the table data one cycle later; field=0; go to SEND_NODE.
  - SEND_NODE: send one field per message. On ack, field++. After WEIGHT: addr++ and go to FETCH, or go to SEND_RUN if addr==N-1.
  - SEND_RUN: ack → WAIT_RESULT.
  - WAIT_RESULT: result received → DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Message count per run is 4N+2.
- start while busy is ignored.
- num_nodes > MAX_NODES is clamped to MAX_NODES.
- If ack arrives in the same cycle rdy first rises, it is accepted.

Optional Feature:
TREEVAL_DRV_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_RESULT.
  - On reaching TIMEOUT_CYCLES: set `timeout` (sticky until next start), leave result_* unchanged, pulse done, and go to IDLE.
- Undefined:
  - No counter; WAIT_RESULT waits indefinitely.
  - `timeout` is tied to 0.

Decomposition:
- treeval_pkg holds:
  - the cmd, cfg and node-field encodings;
  - the field bit positions;
  - the result field positions;
  - the state enum.
  The controller shares this package.
- Sub-module treeval_msg_tx: a single-message rdy/ack holder (load strobe, out_msg_rdy/out_msg, accepted pulse).

Test Plan:
- N=0: start → exactly two messages, 64'h8000_0000_0000_0000 then 64'h0. Return in_msg=64'h17FD → result_exp=-3, result_act=5, done pulse.
- N=3: messages in order:
  - 64'h8000_0000_0000_0003;
  - 12 NODE messages in order addr 0..2, fields P/A/R/W;
  - RUN.
  For node 1 with reward -5, the REWARD message is 64'h4180_0000_0000_FFFB.
- Delayed acks (0–10 random cycles): out_msg stable while rdy=1; rdy drops exactly one cycle after each ack; no message lost or duplicated.
- rst asserted mid-SEND_NODE: out_msg_rdy=0 asynchronously; next start replays from CONFIG.
- start pulsed while busy and stray in_msg_rdy during SEND_CFG: start is ignored; the stray message is acked and discarded; result_* unchanged.
- TREEVAL_DRV_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no result → timeout=1 and done pulse after 16 cycles in WAIT_RESULT.
